// File: rtl/sudoku_uart.sv
// rtl/sudoku_uart.sv - Wishbone 8N1 UART for the Sudoku accelerator serial link
// Optional SUDOKU_UART_RX_FIFO_EN selects an RX_DEPTH-entry receive FIFO instead of a holding register.
module sudoku_uart #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0100,
  parameter logic [15:0] DEFAULT_DIV = 16'd867,
  parameter int          RX_DEPTH    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        ser_tx_oeb,
  output logic        irq
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [15:0] div, div_new;
  logic [1:0]  irq_en;
  logic        rx_overrun, frame_err;
  logic        req, req_q, hit;
  logic        wr_data, wr_status, wr_div, wr_irqen, rd_data;
  logic        rx_valid, rx_full, rx_push, rx_pop, rx_ferr;
  logic [7:0]  rx_head, rx_byte;
  logic [31:0] rdata;
  logic        unused_bits;

  logic [1:0]  tx_state;
  logic [15:0] tx_div, tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_line, tx_busy;

  logic        rx_s1, rx_s2, rx_prev;
  logic [1:0]  rx_state;
  logic [15:0] rx_div, rx_cnt, rx_half;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;

  assign ser_tx_oeb  = 1'b0;
  assign unused_bits = ^{wb_dat_i[31:16], wb_adr_i[1:0], wb_sel_i[3:2], (RX_DEPTH > 1)};

  // One ack per strobe assertion: a held strobe is only seen as new once.
  assign req       = wb_cyc_i & wb_stb_i & (wb_adr_i[31:4] == BASE_ADDR[31:4]);
  assign hit       = req & ~req_q;
  assign wr_data   = hit & wb_we_i & (wb_adr_i[3:2] == 2'd0) & wb_sel_i[0];
  assign wr_status = hit & wb_we_i & (wb_adr_i[3:2] == 2'd1) & wb_sel_i[0];
  assign wr_div    = hit & wb_we_i & (wb_adr_i[3:2] == 2'd2);
  assign wr_irqen  = hit & wb_we_i & (wb_adr_i[3:2] == 2'd3) & wb_sel_i[0];
  assign rd_data   = hit & ~wb_we_i & (wb_adr_i[3:2] == 2'd0);
  assign rx_pop    = rd_data & rx_valid;
  assign div_new   = {wb_sel_i[1] ? wb_dat_i[15:8] : div[15:8],
                      wb_sel_i[0] ? wb_dat_i[7:0]  : div[7:0]};

  always_comb begin
    rdata = 32'd0;
    case (wb_adr_i[3:2])
      2'd0:    rdata = {24'd0, rx_valid ? rx_head : 8'd0};
      2'd1:    rdata = {27'd0, frame_err, rx_overrun, tx_busy, rx_full, rx_valid};
      2'd2:    rdata = {16'd0, div};
      default: rdata = {30'd0, irq_en};
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      req_q    <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      req_q    <= req;
      wb_ack_o <= hit;
      wb_dat_o <= (hit & ~wb_we_i) ? rdata : 32'd0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      div        <= DEFAULT_DIV;
      irq_en     <= 2'b00;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_div) div <= (div_new < 16'd3) ? 16'd3 : div_new;
      if (wr_irqen) irq_en <= wb_dat_i[1:0];
      if (wr_status & wb_dat_i[3]) rx_overrun <= 1'b0;
      if (wr_status & wb_dat_i[4]) frame_err <= 1'b0;
      if (rx_push & rx_full & ~rx_pop) rx_overrun <= 1'b1;
      if (rx_ferr) frame_err <= 1'b1;
      irq <= (irq_en[0] & rx_valid) | (irq_en[1] & ~tx_busy);
    end
  end

  // Transmitter: ser_tx is registered, so the line trails the state by one clock.
  assign tx_busy = (tx_state != S_IDLE);

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = tx_shift[0];
      default: tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tx_state <= S_IDLE;
      tx_div   <= 16'd0;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      ser_tx   <= 1'b1;
    end else begin
      ser_tx <= tx_line;
      if (tx_state == S_IDLE) begin
        if (wr_data) begin
          tx_state <= S_START;
          tx_div   <= div;
          tx_cnt   <= 16'd0;
          tx_bit   <= 3'd0;
          tx_shift <= wb_dat_i[7:0];
        end
      end else if (tx_cnt != tx_div) begin
        tx_cnt <= tx_cnt + 16'd1;
      end else begin
        tx_cnt <= 16'd0;
        case (tx_state)
          S_START: tx_state <= S_DATA;
          S_DATA: begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state <= S_STOP;
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  // Receiver: a frame error returns to IDLE directly; a new start needs a fresh high->low edge.
  assign rx_half = (rx_div >> 1) + {15'd0, rx_div[0]};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_div   <= 16'd0;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
      rx_byte  <= 8'd0;
      rx_push  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1   <= ser_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_push <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_state)
        S_IDLE: if (rx_prev & ~rx_s2) begin
          rx_state <= S_START;
          rx_div   <= div;
          rx_cnt   <= 16'd1;
        end
        S_START: if (rx_cnt == rx_half - 16'd1) begin
          rx_cnt   <= 16'd0;
          rx_bit   <= 3'd0;
          rx_state <= rx_s2 ? S_IDLE : S_DATA;
        end else rx_cnt <= rx_cnt + 16'd1;
        S_DATA: if (rx_cnt == rx_div) begin
          rx_cnt   <= 16'd0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= S_STOP;
        end else rx_cnt <= rx_cnt + 16'd1;
        default: if (rx_cnt == rx_div) begin
          rx_state <= S_IDLE;
          if (rx_s2) begin
            rx_push <= 1'b1;
            rx_byte <= rx_shift;
          end else rx_ferr <= 1'b1;
        end else rx_cnt <= rx_cnt + 16'd1;
      endcase
    end
  end

`ifdef SUDOKU_UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_DEPTH);
  logic [7:0]  rx_mem [RX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_wr;

  assign rx_valid = (wr_ptr != rd_ptr);
  assign rx_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign rx_head  = rx_mem[rd_ptr[AW-1:0]];
  assign fifo_wr  = rx_push & (~rx_full | rx_pop);

  always_ff @(posedge wb_clk_i) begin
    if (fifo_wr) rx_mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (rx_pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (fifo_wr) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
    end
  end
`else
  logic [7:0] rx_hold;
  logic       rx_hold_v;

  assign rx_valid = rx_hold_v;
  assign rx_full  = rx_hold_v;
  assign rx_head  = rx_hold;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rx_hold   <= 8'd0;
      rx_hold_v <= 1'b0;
    end else if (rx_push & (~rx_hold_v | rx_pop)) begin
      rx_hold   <= rx_byte;
      rx_hold_v <= 1'b1;
    end else if (rx_pop) begin
      rx_hold_v <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sudoku_uart.sv
// tb/tb_sudoku_uart.sv - randomized self-checking bench for sudoku_uart
module tb_sudoku_uart;
  localparam logic [31:0] BASE = 32'h3000_0100;
`ifdef SUDOKU_UART_RX_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = 32'd0, dat_w = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] dat_r;
  logic        ack, rx = 1'b1, tx, tx_oeb, irq;

  int n_pass = 0, n_total = 0;
  logic [7:0]  rx_q[$];
  logic        m_ovr = 1'b0, m_ferr = 1'b0;
  logic [15:0] m_div = 16'd867;

  sudoku_uart dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel), .wb_dat_o(dat_r), .wb_ack_o(ack),
    .ser_rx(rx), .ser_tx(tx), .ser_tx_oeb(tx_oeb), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  function automatic logic [15:0] div_model(input logic [15:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [15:0] v;
    v = old;
    if (s[0]) v[7:0] = d[7:0];
    if (s[1]) v[15:8] = d[15:8];
    return (v < 16'd3) ? 16'd3 : v;
  endfunction

  function automatic logic [31:0] status_model();
    return {27'd0, m_ferr, m_ovr, 1'b0, rx_q.size() == CAP, rx_q.size() > 0};
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (rx_q.size() < CAP) rx_q.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic got);
    got = 1'b0;
    rd  = 32'd0;
    cyc = 1'b1; stb = 1'b1; we = wr; adr = a; dat_w = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; rd = dat_r; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL bus_timeout addr=%h: no ack within 8 cycles, ack required", a);
    end
    @(negedge clk);
  endtask

  task automatic rd(input int off, output logic [31:0] d);
    logic g;
    bus(1'b0, BASE + 32'(off * 4), 32'd0, 4'hF, d, g);
  endtask

  task automatic wr(input int off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    logic g;
    bus(1'b1, BASE + 32'(off * 4), d, s, r, g);
  endtask

  task automatic set_div(input int d);
    wr(2, 32'(d), 4'b0011);
    m_div = div_model(m_div, 32'(d), 4'b0011);
  endtask

  task automatic send_frame(input logic [7:0] b, input int d, input logic stop);
    for (int k = 0; k < 10; k++) begin
      rx = (k == 9) ? stop : frame_bit(b, k);
      repeat (d + 1) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (2) @(negedge clk);
    n_total++; if (tx !== 1'b1 || ack !== 1'b0 || dat_r !== 32'd0 || irq !== 1'b0 || tx_oeb !== 1'b0)
      $display("FAIL reset_outputs: tx=%b ack=%b dat=%h irq=%b oeb=%b, required 1 0 0 0 0", tx, ack, dat_r, irq, tx_oeb);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    rd(1, r);
    n_total++; if (r !== 32'd0) $display("FAIL reset_status: got %h required 00000000", r); else n_pass++;
    rd(2, r);
    n_total++; if (r !== 32'd867) $display("FAIL reset_div: got %0d required 867", r); else n_pass++;
    wr(0, 32'h00, 4'b0001);
    repeat (10) @(negedge clk);
    n_total++; if (tx !== 1'b0) $display("FAIL tx_start_before_reset: got %b required 0", tx); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (tx !== 1'b1) $display("FAIL async_reset_tx: got %b required 1", tx); else n_pass++;
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(1, r);
    n_total++; if (r !== 32'd0) $display("FAIL status_after_abort: got %h required 00000000", r); else n_pass++;
    m_div = 16'd867;
  endtask

  task automatic test_div();
    logic [31:0] r;
    logic [31:0] vals[4] = '{32'h0000_0001, 32'h0000_1234, 32'h0000_AB00, 32'h0000_0002};
    logic [3:0]  sels[4] = '{4'b0011, 4'b0011, 4'b0010, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      wr(2, vals[i], sels[i]);
      m_div = div_model(m_div, vals[i], sels[i]);
      rd(2, r);
      n_total++; if (r !== {16'd0, m_div}) $display("FAIL div_write_%0d: got %h required %h", i, r, m_div); else n_pass++;
    end
  endtask

  task automatic test_tx(input logic [7:0] b, input int d);
    logic [31:0] r, rr;
    logic got, gg, exp_line, exp_irq;
    int n;
    set_div(d);
    wr(3, 32'd2, 4'b0001);
    n = 10 * (d + 1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; dat_w = {24'd0, b}; sel = 4'b0001; got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin @(negedge clk); got = ack; end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    n_total++; if (!got) $display("FAIL tx_write_ack: no ack, ack required"); else n_pass++;
    n_total++; if (tx !== 1'b1 || irq !== 1'b1) $display("FAIL tx_ack_cycle: tx=%b irq=%b required 1 1", tx, irq); else n_pass++;
    fork
      begin
        for (int o = 1; o <= n + 2; o++) begin
          @(negedge clk);
          exp_line = (o <= n) ? frame_bit(b, (o - 1) / (d + 1)) : 1'b1;
          exp_irq  = (o > n);
          n_total++; if (tx !== exp_line || irq !== exp_irq)
            $display("FAIL tx_frame byte=%h div=%0d off=%0d: tx=%b irq=%b required %b %b", b, d, o, tx, irq, exp_line, exp_irq);
          else n_pass++;
        end
      end
      begin
        repeat (9) @(negedge clk);
        bus(1'b1, BASE, {24'd0, ~b}, 4'b0001, rr, gg);
        repeat (10) @(negedge clk);
        bus(1'b0, BASE + 32'd4, 32'd0, 4'hF, rr, gg);
        n_total++; if (rr !== 32'h4) $display("FAIL tx_busy_mid: status %h required 00000004", rr); else n_pass++;
      end
    join
    rd(1, r);
    n_total++; if (r !== status_model()) $display("FAIL tx_busy_end: status %h required %h", r, status_model()); else n_pass++;
    wr(3, 32'd0, 4'b0001);
  endtask

  task automatic rx_byte_check(input logic [7:0] b, input int d);
    logic [31:0] r, e;
    set_div(d);
    send_frame(b, d, 1'b1);
    model_push(b);
    repeat (4) @(negedge clk);
    rd(1, r);
    n_total++; if (r !== status_model()) $display("FAIL rx_status byte=%h: got %h required %h", b, r, status_model()); else n_pass++;
    e = (rx_q.size() > 0) ? {24'd0, rx_q.pop_front()} : 32'd0;
    rd(0, r);
    n_total++; if (r !== e) $display("FAIL rx_data: got %h required %h", r, e); else n_pass++;
    rd(1, r);
    n_total++; if (r !== status_model()) $display("FAIL rx_status_after_pop: got %h required %h", r, status_model()); else n_pass++;
  endtask

  task automatic test_rx();
    logic [31:0] r;
    rx_byte_check(8'hC3, 15);
    rd(0, r);
    n_total++; if (r !== 32'd0) $display("FAIL rx_empty_read: got %h required 00000000", r); else n_pass++;
    for (int i = 0; i < 4; i++) rx_byte_check(8'($urandom), 7 + int'($urandom_range(0, 13)));
  endtask

  task automatic test_errors();
    logic [31:0] r;
    set_div(15);
    send_frame(8'($urandom), 15, 1'b0);
    m_ferr = 1'b1;
    repeat (4) @(negedge clk);
    rd(1, r);
    n_total++; if (r !== status_model()) $display("FAIL frame_err: status %h required %h", r, status_model()); else n_pass++;
    wr(1, 32'h10, 4'b0000);
    rd(1, r);
    n_total++; if (r !== status_model()) $display("FAIL ferr_clear_nosel: status %h required %h", r, status_model()); else n_pass++;
    wr(1, 32'h10, 4'b0001);
    m_ferr = 1'b0;
    rd(1, r);
    n_total++; if (r !== status_model()) $display("FAIL ferr_clear: status %h required %h", r, status_model()); else n_pass++;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    rd(1, r);
    n_total++; if (r !== status_model()) $display("FAIL glitch: status %h required %h", r, status_model()); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] r, e;
    set_div(15);
    for (int i = 0; i <= CAP; i++) begin
      e = 32'($urandom_range(0, 255));
      send_frame(e[7:0], 15, 1'b1);
      model_push(e[7:0]);
    end
    repeat (4) @(negedge clk);
    rd(1, r);
    n_total++; if (r !== status_model()) $display("FAIL overflow_status: got %h required %h", r, status_model()); else n_pass++;
    for (int i = 0; i < CAP; i++) begin
      e = {24'd0, rx_q.pop_front()};
      rd(0, r);
      n_total++; if (r !== e) $display("FAIL overflow_read_%0d: got %h required %h", i, r, e); else n_pass++;
    end
    rd(0, r);
    n_total++; if (r !== 32'd0) $display("FAIL overflow_drained: got %h required 00000000", r); else n_pass++;
    wr(1, 32'h08, 4'b0001);
    m_ovr = 1'b0;
    rd(1, r);
    n_total++; if (r !== status_model()) $display("FAIL ovr_clear: status %h required %h", r, status_model()); else n_pass++;
  endtask

  task automatic test_irq();
    logic [31:0] r, e;
    logic [7:0] b;
    int lat;
    b = 8'($urandom);
    set_div(15);
    wr(3, 32'd1, 4'b0001);
    n_total++; if (irq !== 1'b0) $display("FAIL irq_idle: got %b required 0", irq); else n_pass++;
    lat = 0;
    fork
      send_frame(b, 15, 1'b1);
      for (int k = 1; k <= 400 && lat == 0; k++) begin
        @(negedge clk);
        if (irq) lat = k;
      end
    join
    model_push(b);
    n_total++; if (lat < 153 || lat > 157) $display("FAIL irq_latency: got %0d cycles required 153..157", lat); else n_pass++;
    rd(1, r);
    n_total++; if (r !== status_model()) $display("FAIL irq_status: got %h required %h", r, status_model()); else n_pass++;
    e = {24'd0, rx_q.pop_front()};
    rd(0, r);
    n_total++; if (r !== e) $display("FAIL irq_data: got %h required %h", r, e); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL irq_drop: got %b required 0", irq); else n_pass++;
    wr(3, 32'd0, 4'b0001);
  endtask

  task automatic test_bus();
    logic [31:0] addrs[2] = '{BASE + 32'h4, BASE + 32'h10};
    int exp_acks[2] = '{1, 0};
    int acks;
    for (int t = 0; t < 2; t++) begin
      acks = 0;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = addrs[t]; sel = 4'hF;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (ack) acks++;
      end
      n_total++; if (dat_r !== 32'd0) $display("FAIL held_dat_zero_%0d: got %h required 00000000", t, dat_r); else n_pass++;
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      n_total++; if (acks != exp_acks[t]) $display("FAIL held_strobe_acks_%0d: got %0d required %0d", t, acks, exp_acks[t]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_div();
    test_tx(8'h5A, 3);
    for (int i = 0; i < 3; i++) test_tx(8'($urandom), 3 + int'($urandom_range(0, 3)));
    test_rx();
    test_errors();
    test_overflow();
    test_irq();
    test_bus();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
